// File: rtl/mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_sequencer
// Description : Round-robin arbiter and command sequencer between NCH request
//               channels and an Avalon-style memory port. Tracks up to MAX_OUT
//               in-flight reads in a tag FIFO, routes in-order read data back
//               to the owning channel, and raises a watchdog on a stalled port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int NCH     = 2,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          i_req,
  input  logic [NCH-1:0]          i_wr,
  input  logic [NCH*ADDR_W-1:0]   i_addr,
  input  logic [NCH*DATA_W-1:0]   i_wrdata,
  output logic [NCH-1:0]          o_grant,
  output logic [NCH-1:0]          o_rdvalid,
  output logic [DATA_W-1:0]       o_rddata,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic                    o_mem_rd,
  output logic                    o_mem_wr,
  output logic [DATA_W-1:0]       o_mem_wrdata,
  input  logic                    i_mem_wait,
  input  logic [DATA_W-1:0]       i_mem_rddata,
  input  logic                    i_mem_rddatavalid,
  input  logic                    i_err_clr,
  output logic                    o_timeout,
  output logic                    o_proto_err
);

  localparam int c_CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_OUT_W = $clog2(MAX_OUT + 1);
  localparam int c_PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int c_WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CH_W-1:0]   r_rr_ptr, r_ch, w_sel, w_head;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wrdata, r_rddata;
  logic [c_CH_W-1:0]   r_tag [MAX_OUT];
  logic [c_PTR_W-1:0]  r_wptr, r_rptr;
  logic [c_OUT_W-1:0]  r_outst;
  logic [c_WD_W-1:0]   r_wdog;
  logic                r_timeout, r_proto;
  logic [NCH-1:0]      r_rdvalid, w_elig, w_grant;
  logic                w_any, w_grant_en, w_accept, w_live, w_push, w_pop, w_spur;
  logic                w_wd_run, w_wd_clr, w_wd_hit;

  // A write never needs a tag slot, so only reads are held back by a full FIFO
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_elig[c] = i_req[c] && (i_wr[c] || (r_outst < c_OUT_W'(MAX_OUT)));
    end
  end

  // Round-robin pick: scan from farthest to nearest so the channel right after rr_ptr wins
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      if (w_elig[c_CH_W'((int'(r_rr_ptr) + k) % NCH)]) begin
        w_sel = c_CH_W'((int'(r_rr_ptr) + k) % NCH);
        w_any = 1'b1;
      end
    end
  end

  assign w_head   = r_tag[r_rptr];
  assign w_accept = (r_state == S_ISSUE) && !i_mem_wait;
  assign w_live   = (r_state != S_ERR);
  assign w_push   = w_accept && !r_wr;
  assign w_pop    = w_live && i_mem_rddatavalid && (r_outst != '0);
  assign w_spur   = w_live && i_mem_rddatavalid && (r_outst == '0);
  assign w_wd_run = (r_state == S_ISSUE) || (r_outst != '0);
  assign w_wd_clr = w_accept || i_mem_rddatavalid || ((r_state == S_IDLE) && (r_outst == '0));
  assign w_wd_hit = (TIMEOUT != 0) && w_live && w_wd_run && !w_wd_clr &&
                    (r_wdog == c_WD_W'(TIMEOUT - 1));

  // Next-state and grant decode; a watchdog hit overrides any other move
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wd_hit) begin
          w_state_nxt = S_ERR;
        end else if (w_any) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_wd_hit)      w_state_nxt = S_ERR;
        else if (w_accept) w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (i_err_clr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One-hot grant for the selected channel; forced low while reset is held
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_grant[c] = w_grant_en && (w_sel == c_CH_W'(c));
    end
  end

  assign o_grant      = rst ? '0 : w_grant;
  assign o_mem_rd     = (r_state == S_ISSUE) && !r_wr;
  assign o_mem_wr     = (r_state == S_ISSUE) && r_wr;
  assign o_mem_addr   = r_addr;
  assign o_mem_wrdata = r_wrdata;
  assign o_rdvalid    = r_rdvalid;
  assign o_rddata     = r_rddata;
  assign o_timeout    = r_timeout;
  assign o_proto_err  = r_proto;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch the granted command so the channel may drop its request immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= c_CH_W'(NCH - 1);
      r_ch     <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wrdata <= '0;
    end else if (w_grant_en) begin
      r_rr_ptr <= w_sel;
      r_ch     <= w_sel;
      r_wr     <= i_wr[w_sel];
      r_addr   <= i_addr[int'(w_sel)*ADDR_W +: ADDR_W];
      r_wrdata <= i_wrdata[int'(w_sel)*DATA_W +: DATA_W];
    end
  end

  // Tag FIFO of read owners; the outstanding count doubles as FIFO occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_outst <= '0;
      for (int i = 0; i < MAX_OUT; i++) r_tag[i] <= '0;
    end else if (r_state == S_ERR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_outst <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= r_ch;
        r_wptr <= (r_wptr == c_PTR_W'(MAX_OUT - 1)) ? '0 : r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_PTR_W'(MAX_OUT - 1)) ? '0 : r_rptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop)      r_outst <= r_outst + c_OUT_W'(1);
      else if (!w_push && w_pop) r_outst <= r_outst - c_OUT_W'(1);
    end
  end

  // Watchdog counter and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
      r_proto   <= 1'b0;
    end else begin
      if (r_state == S_ERR) begin
        if (i_err_clr) r_wdog <= '0;
      end else if (w_wd_clr || !w_wd_run) begin
        r_wdog <= '0;
      end else if ((TIMEOUT != 0) && !w_wd_hit) begin
        r_wdog <= r_wdog + c_WD_W'(1);
      end
      if (w_wd_hit)                           r_timeout <= 1'b1;
      else if ((r_state == S_ERR) && i_err_clr) r_timeout <= 1'b0;
      if (i_err_clr)   r_proto <= 1'b0;
      else if (w_spur) r_proto <= 1'b1;
    end
  end

  // Registered read return routed to the FIFO-head owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdvalid <= '0;
      r_rddata  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        r_rdvalid[c] <= w_pop && (w_head == c_CH_W'(c));
      end
      if (w_pop) r_rddata <= i_mem_rddata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_sequencer
// Description : Directed self-checking bench for mem_req_sequencer
//               (NCH=2, MAX_OUT=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_req, i_wr;
  logic [31:0] i_addr, i_wrdata;
  logic [1:0]  o_grant, o_rdvalid;
  logic [15:0] o_rddata, o_mem_addr, o_mem_wrdata, i_mem_rddata;
  logic        o_mem_rd, o_mem_wr, i_mem_wait, i_mem_rddatavalid, i_err_clr;
  logic        o_timeout, o_proto_err;

  int n_pass  = 0;
  int n_total = 0;

  mem_req_sequencer #(
    .ADDR_W(16), .DATA_W(16), .NCH(2), .MAX_OUT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wrdata(i_wrdata),
    .o_grant(o_grant), .o_rdvalid(o_rdvalid), .o_rddata(o_rddata),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_mem_wrdata(o_mem_wrdata), .i_mem_wait(i_mem_wait),
    .i_mem_rddata(i_mem_rddata), .i_mem_rddatavalid(i_mem_rddatavalid),
    .i_err_clr(i_err_clr), .o_timeout(o_timeout), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},   32'(o_grant), 0);
    chk({tag, "_rdvalid"}, 32'(o_rdvalid), 0);
    chk({tag, "_rd"},      32'(o_mem_rd), 0);
    chk({tag, "_wr"},      32'(o_mem_wr), 0);
    chk({tag, "_addr"},    32'(o_mem_addr), 0);
    chk({tag, "_rddata"},  32'(o_rddata), 0);
    chk({tag, "_tmo"},     32'(o_timeout), 0);
    chk({tag, "_perr"},    32'(o_proto_err), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_req = '0; i_wr = '0; i_addr = '0; i_wrdata = '0;
    i_mem_wait = 1'b0; i_mem_rddata = '0; i_mem_rddatavalid = 1'b0; i_err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset");

    // Single read on ch0 with 3 wait cycles, data 2 cycles after acceptance
    i_req = 2'b01; i_addr = {16'h0000, 16'h0010}; i_mem_wait = 1'b1;
    #1 chk("t1_grant", 32'(o_grant), 32'h1);
    tick();
    i_req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      i_mem_wait = (k < 3);
      #1;
      chk("t1_rd_held", 32'(o_mem_rd), 1);
      chk("t1_addr_stable", 32'(o_mem_addr), 32'h0010);
      tick();
    end
    i_mem_wait = 1'b0;
    chk("t1_rd_dropped", 32'(o_mem_rd), 0);
    tick();
    i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'hBEEF;
    chk("t1_no_early_rdvalid", 32'(o_rdvalid), 0);
    tick();
    i_mem_rddatavalid = 1'b0;
    chk("t1_rdvalid", 32'(o_rdvalid), 32'h1);
    chk("t1_rddata", 32'(o_rddata), 32'hBEEF);
    tick();
    chk("t1_rdvalid_pulse", 32'(o_rdvalid), 0);

    // Both channels reading continuously: grants alternate, data routed in order
    pulse_reset();
    i_req = 2'b11; i_wr = 2'b00; i_addr = {16'h0200, 16'h0100};
    for (int g = 0; g < 4; g++) begin
      #1 chk("t2_grant", 32'(o_grant), (g % 2) ? 32'h2 : 32'h1);
      tick();
      if (g == 3) i_req = 2'b00;
      #1;
      chk("t2_nogrant_issue", 32'(o_grant), 0);
      chk("t2_rd", 32'(o_mem_rd), 1);
      chk("t2_addr", 32'(o_mem_addr), (g % 2) ? 32'h0200 : 32'h0100);
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'hA000 + 16'(g);
      tick();
      chk("t2_rdvalid", 32'(o_rdvalid), (g % 2) ? 32'h2 : 32'h1);
      chk("t2_rddata", 32'(o_rddata), 32'hA000 + g);
    end
    i_mem_rddatavalid = 1'b0;
    tick();
    chk("t2_rdvalid_idle", 32'(o_rdvalid), 0);

    // Outstanding limit: 4 reads, 5th blocked, write on ch1 still granted
    pulse_reset();
    i_req = 2'b01; i_wr = 2'b00; i_addr = {16'h0400, 16'h0300}; i_wrdata = {16'h5555, 16'h0000};
    for (int g = 0; g < 4; g++) begin
      #1 chk("t3_grant", 32'(o_grant), 32'h1);
      tick();
      chk("t3_rd", 32'(o_mem_rd), 1);
      tick();
    end
    #1 chk("t3_full_nogrant", 32'(o_grant), 0);
    tick();
    i_req = 2'b11; i_wr = 2'b10;
    #1 chk("t3_write_grant", 32'(o_grant), 32'h2);
    tick();
    i_req = 2'b01;
    #1;
    chk("t3_mem_wr", 32'(o_mem_wr), 1);
    chk("t3_mem_rd_low", 32'(o_mem_rd), 0);
    chk("t3_wr_addr", 32'(o_mem_addr), 32'h0400);
    chk("t3_wr_data", 32'(o_mem_wrdata), 32'h5555);
    tick();
    #1 chk("t3_still_full", 32'(o_grant), 0);
    i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'h1111;
    tick();
    i_mem_rddatavalid = 1'b0;
    #1;
    chk("t3_fifth_grant", 32'(o_grant), 32'h1);
    chk("t3_rdvalid", 32'(o_rdvalid), 32'h1);
    chk("t3_rddata", 32'(o_rddata), 32'h1111);
    tick();
    i_req = 2'b00;
    chk("t3_fifth_rd", 32'(o_mem_rd), 1);
    chk("t3_fifth_addr", 32'(o_mem_addr), 32'h0300);
    tick();
    for (int g = 0; g < 4; g++) begin
      i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'hB000 + 16'(g);
      tick();
      chk("t3_drain_rdvalid", 32'(o_rdvalid), 32'h1);
      chk("t3_drain_data", 32'(o_rddata), 32'hB000 + g);
    end
    i_mem_rddatavalid = 1'b0;
    tick();

    // Read acceptance coincident with return of an earlier read
    i_req = 2'b01; i_wr = 2'b00; i_addr = {16'h0700, 16'h0600};
    #1 chk("t4_grant0", 32'(o_grant), 32'h1);
    tick();
    i_req = 2'b00;
    tick();
    i_req = 2'b10;
    #1 chk("t4_grant1", 32'(o_grant), 32'h2);
    tick();
    i_req = 2'b00; i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'h2222;
    #1 chk("t4_rd_addr", 32'(o_mem_addr), 32'h0700);
    tick();
    i_mem_rddatavalid = 1'b0;
    chk("t4_rdvalid0", 32'(o_rdvalid), 32'h1);
    chk("t4_rddata0", 32'(o_rddata), 32'h2222);
    i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'h3333;
    tick();
    i_mem_rddatavalid = 1'b0;
    chk("t4_rdvalid1", 32'(o_rdvalid), 32'h2);
    chk("t4_rddata1", 32'(o_rddata), 32'h3333);
    chk("t4_no_perr", 32'(o_proto_err), 0);
    tick();

    // Watchdog: wait stuck high for 8 cycles in S_ISSUE
    i_req = 2'b01; i_addr = {16'h0000, 16'h0800}; i_mem_wait = 1'b1;
    #1 chk("t5_grant", 32'(o_grant), 32'h1);
    tick();
    i_req = 2'b00;
    for (int k = 0; k < 8; k++) begin
      chk("t5_rd_held", 32'(o_mem_rd), 1);
      chk("t5_tmo_low", 32'(o_timeout), 0);
      tick();
    end
    chk("t5_tmo_set", 32'(o_timeout), 1);
    chk("t5_rd_drop", 32'(o_mem_rd), 0);
    i_req = 2'b01;
    #1 chk("t5_err_nogrant", 32'(o_grant), 0);
    i_mem_wait = 1'b0; i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("t5_tmo_clr", 32'(o_timeout), 0);
    #1 chk("t5_regrant", 32'(o_grant), 32'h1);
    tick();
    i_req = 2'b00;
    chk("t5_rd_again", 32'(o_mem_rd), 1);
    tick();
    i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'h4444;
    tick();
    i_mem_rddatavalid = 1'b0;
    chk("t5_rdvalid", 32'(o_rdvalid), 32'h1);
    chk("t5_rddata", 32'(o_rddata), 32'h4444);
    tick();

    // Spurious return, error clear, then reset mid-read
    i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'h9999;
    tick();
    i_mem_rddatavalid = 1'b0;
    chk("t6_perr_set", 32'(o_proto_err), 1);
    chk("t6_no_rdvalid", 32'(o_rdvalid), 0);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("t6_perr_clr", 32'(o_proto_err), 0);
    i_req = 2'b01; i_addr = {16'h0000, 16'h0900}; i_mem_wait = 1'b1;
    tick();
    i_req = 2'b00;
    chk("t6_rd_before_rst", 32'(o_mem_rd), 1);
    rst = 1'b1;
    #1 chk_all_zero("t6_async_rst");
    tick();
    chk_all_zero("t6_rst_edge");
    rst = 1'b0; i_mem_wait = 1'b0;
    tick();
    i_mem_rddatavalid = 1'b1; i_mem_rddata = 16'h7777;
    tick();
    i_mem_rddatavalid = 1'b0;
    chk("t6_late_return_perr", 32'(o_proto_err), 1);
    chk("t6_late_return_norv", 32'(o_rdvalid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
